// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch queue.
package if_pkg;

  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_BR  = 2'b01;
  localparam logic [1:0]  PCSRC_J   = 2'b10;
  localparam logic [1:0]  PCSRC_RST = 2'b11;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } if_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO; occupancy counter decides full/empty, clear empties it in one cycle.
module ifq_fifo
  import if_pkg::*;
#(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer and occupancy; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/if_fetch_queue.sv
// MIPS IF stage: PC select, prefetch queue and IF/ID register.
// Optional IFQ_BYPASS_EN loads a fetch straight into IF/ID when the queue is empty.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  int              DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = 32'h0,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [1:0]      pcsource,
  input  logic [XLEN-1:0] bpc,
  input  logic [XLEN-1:0] jpc,
  input  logic            load_depen,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc4,
  output logic [XLEN-1:0] id_inst,
  output logic [CW-1:0]   fifo_count
);

  logic [XLEN-1:0]   pc_q, pc_d, pc_plus4_s;
  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   id_pc4_q, id_pc4_d, id_inst_q, id_inst_d;
  logic              redirect_s, pop_s, push_s, bypass_s;
  logic              full_s, empty_s;
  logic [2*XLEN-1:0] head_s;
  logic [CW-1:0]     count_s;

  assign pc_plus4_s = pc_q + XLEN'(4);
  assign redirect_s = (pcsource != PCSRC_SEQ);
  assign pop_s      = !load_depen && !empty_s;
  assign push_s     = imem_ready && (!full_s || pop_s) && !redirect_s;

`ifdef IFQ_BYPASS_EN
  assign bypass_s = push_s && empty_s && !load_depen;
`else
  assign bypass_s = 1'b0;
`endif

  ifq_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .clear_i (redirect_s),
    .push_i  (push_s && !bypass_s),
    .pop_i   (pop_s),
    .wdata_i ({pc_plus4_s, imem_rdata}),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next fetch PC; no delay slot, the redirected fetch is simply dropped.
  always_comb begin
    pc_d = pc_q;
    case (pcsource)
      PCSRC_SEQ: pc_d = push_s ? pc_plus4_s : pc_q;
      PCSRC_BR:  pc_d = bpc;
      PCSRC_J:   pc_d = jpc;
      PCSRC_RST: pc_d = RESET_PC;
      default:   pc_d = pc_q;
    endcase
  end

  // IF/ID register next state: redirect, stall hold, head load, bypass or bubble.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc4_d   = id_pc4_q;
    id_inst_d  = id_inst_q;
    if (redirect_s) begin
      id_valid_d = 1'b0;
      id_pc4_d   = {XLEN{1'b0}};
      id_inst_d  = XLEN'(NOP_INST);
    end else if (load_depen) begin
      id_valid_d = id_valid_q;
    end else if (!empty_s) begin
      id_valid_d = 1'b1;
      id_pc4_d   = head_s[2*XLEN-1:XLEN];
      id_inst_d  = head_s[XLEN-1:0];
    end else if (bypass_s) begin
      id_valid_d = 1'b1;
      id_pc4_d   = pc_plus4_s;
      id_inst_d  = imem_rdata;
    end else begin
      id_valid_d = 1'b0;
      id_inst_d  = XLEN'(NOP_INST);
    end
  end

  // PC and IF/ID state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc4_q   <= {XLEN{1'b0}};
      id_inst_q  <= XLEN'(NOP_INST);
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc4_q   <= id_pc4_d;
      id_inst_q  <= id_inst_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign id_valid   = id_valid_q;
  assign id_pc4     = id_pc4_q;
  assign id_inst    = id_inst_q;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a queue-based scoreboard of fetched entries.
module tb_if_fetch_queue;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc;
  logic        load_depen;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_ready;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_pc4, id_inst;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  if_entry_t   sb[$];
  logic [31:0] m_pc, e_pc4, e_inst;
  logic        e_valid;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'hA000_0000;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .load_depen (load_depen),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc         (pc),
    .id_valid   (id_valid),
    .id_pc4     (id_pc4),
    .id_inst    (id_inst),
    .fifo_count (fifo_count)
  );

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task model_reset();
    sb.delete();
    m_pc    = RESET_PC;
    e_valid = 1'b0;
    e_pc4   = 32'h0;
    e_inst  = 32'h0;
  endtask

  // Predict the effect of the coming rising edge from the current inputs.
  task predict();
    if_entry_t ent, head;
    bit do_pop, do_push, byp;
    if (pcsource != 2'b00) begin
      sb.delete();
      e_valid = 1'b0;
      e_pc4   = 32'h0;
      e_inst  = 32'h0;
      case (pcsource)
        2'b01:   m_pc = bpc;
        2'b10:   m_pc = jpc;
        default: m_pc = RESET_PC;
      endcase
    end else begin
      do_pop   = !load_depen && (sb.size() != 0);
      do_push  = imem_ready && ((sb.size() < DEPTH) || do_pop);
      ent.pc4  = m_pc + 32'd4;
      ent.inst = m_pc | 32'hA000_0000;
      byp      = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = do_push && !load_depen && (sb.size() == 0);
`endif
      if (load_depen) begin
      end else if (do_pop) begin
        head    = sb.pop_front();
        e_valid = 1'b1;
        e_pc4   = head.pc4;
        e_inst  = head.inst;
      end else if (byp) begin
        e_valid = 1'b1;
        e_pc4   = ent.pc4;
        e_inst  = ent.inst;
      end else begin
        e_valid = 1'b0;
        e_inst  = 32'h0;
      end
      if (do_push && !byp) sb.push_back(ent);
      if (do_push) m_pc = m_pc + 32'd4;
    end
  endtask

  task compare_all();
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("fifo_count", {29'h0, fifo_count}, sb.size());
    chk("id_valid", {31'h0, id_valid}, {31'h0, e_valid});
    chk("id_inst", id_inst, e_inst);
    chk("id_pc4", id_pc4, e_pc4);
  endtask

  task step();
    predict();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    clrn       = 1'b0;
    pcsource   = 2'b00;
    bpc        = 32'h0;
    jpc        = 32'h0;
    load_depen = 1'b0;
    imem_ready = 1'b1;
    model_reset();
    #3;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_count", {29'h0, fifo_count}, 32'h0);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // Startup latency
    step();
    step();
`ifndef IFQ_BYPASS_EN
    chk("start_e2_inst", id_inst, 32'hA000_0000);
    chk("start_e2_pc4", id_pc4, 32'h4);
    chk("start_e2_valid", {31'h0, id_valid}, 32'h1);
    step();
    chk("start_e3_inst", id_inst, 32'hA000_0004);
`else
    step();
`endif

    // Load-use stall fills the queue, then drains in order
    load_depen = 1'b1;
    for (int i = 0; i < 4; i++) step();
`ifndef IFQ_BYPASS_EN
    chk("stall_full_count", {29'h0, fifo_count}, 32'd4);
    chk("stall_pc_hold", pc, 32'h18);
`endif
    load_depen = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Branch redirect with three queued entries
    imem_ready = 1'b0;
    step();
    imem_ready = 1'b1;
    pcsource   = 2'b01;
    bpc        = 32'h100;
    step();
    chk("br_count", {29'h0, fifo_count}, 32'h0);
    chk("br_valid", {31'h0, id_valid}, 32'h0);
    chk("br_pc", pc, 32'h100);
    pcsource = 2'b00;
    step();
`ifdef IFQ_BYPASS_EN
    chk("br_refill_inst", id_inst, 32'hA000_0100);
`endif
    step();
`ifndef IFQ_BYPASS_EN
    chk("br_refill_inst", id_inst, 32'hA000_0100);
`endif
    step();

    // Jump together with a load-use stall: redirect wins
    pcsource   = 2'b10;
    jpc        = 32'h40;
    load_depen = 1'b1;
    step();
    chk("j_valid", {31'h0, id_valid}, 32'h0);
    chk("j_inst", id_inst, 32'h0);
    chk("j_pc", pc, 32'h40);
    pcsource   = 2'b00;
    load_depen = 1'b0;

    // Wait states: imem_ready toggling
    for (int i = 0; i < 8; i++) begin
      imem_ready = (i % 2 == 0);
      step();
    end
    imem_ready = 1'b1;

    // PC wraps at 2^32, then pcsource=11 returns to RESET_PC
    pcsource = 2'b01;
    bpc      = 32'hFFFF_FFF8;
    step();
    pcsource = 2'b00;
    step();
    step();
    chk("wrap_pc", pc, 32'h0);
    step();
    step();
    pcsource = 2'b11;
    step();
    chk("rst_sel_pc", pc, RESET_PC);
    pcsource = 2'b00;
    step();

    // Asynchronous reset mid-stream with a full queue under stall
    load_depen = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_pc", pc, RESET_PC);
    chk("arst_count", {29'h0, fifo_count}, 32'h0);
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_inst", id_inst, 32'h0);
    chk("arst_pc4", id_pc4, 32'h0);
    model_reset();
    load_depen = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    step();
    step();
`ifndef IFQ_BYPASS_EN
    chk("restart_inst", id_inst, 32'hA000_0000);
`endif
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
